// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared VGA timing constants for the scan controller, sprite logic and
// colour logic. Defaults describe standard 640x480 @ 60 Hz timing with a
// 25 MHz pixel rate derived from a 50 MHz system clock.
// Contents:
//   H_* / V_*        horizontal and vertical timing segment lengths
//   H_TOTAL/V_TOTAL  full line / frame lengths in pixels / lines
//   SCREEN_WIDTH/HEIGHT  visible resolution for downstream pixel logic
//   coord_t          10-bit unsigned screen coordinate
//   inSpan()         half-open range test used for sync decode
// ---------------------------------------------------------------------------
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam int SCREEN_WIDTH  = 640;
   localparam int SCREEN_HEIGHT = 480;

   typedef logic [9:0] coord_t;

   // True when pos lies in [lo, hi); all comparisons stay 10-bit unsigned.
   function automatic logic inSpan(coord_t pos, coord_t lo, coord_t hi);
      return (pos >= lo) && (pos < hi);
   endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// ---------------------------------------------------------------------------
// vga_sync_counter
// Pixel-rate divider plus horizontal / vertical scan counters.
// Ports:
//   clk      system clock (rising edge)
//   rst_n    asynchronous active-low reset
//   scanEn   1 = scan runs, 0 = park at origin with the divider cleared
//   pixTick  one-clk pulse every second clk while scanning
//   hPos     horizontal count 0..H_TOTAL-1
//   vPos     vertical count 0..V_TOTAL-1
// ---------------------------------------------------------------------------
module vga_sync_counter
   import vga_pkg::*;
#(
   parameter int H_TOTAL = vga_pkg::H_TOTAL,
   parameter int V_TOTAL = vga_pkg::V_TOTAL
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scanEn,
   output logic       pixTick,
   output logic [9:0] hPos,
   output logic [9:0] vPos
);

   localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

   // The divider register doubles as pixTick: it rises on the first clk
   // after scanning is enabled, so the first pixel period starts at the
   // origin. Counters advance on the edge that ends a pixTick-high clk, and
   // dropping scanEn parks everything at the origin on the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixTick <= 1'b0;
         hPos    <= '0;
         vPos    <= '0;
      end else if (!scanEn) begin
         pixTick <= 1'b0;
         hPos    <= '0;
         vPos    <= '0;
      end else begin
         pixTick <= ~pixTick;
         if (pixTick) begin
            if (hPos == H_LAST) begin
               hPos <= '0;
               if (vPos == V_LAST) begin
                  vPos <= '0;
               end else begin
                  vPos <= vPos + 10'd1;
               end
            end else begin
               hPos <= hPos + 10'd1;
            end
         end
      end
   end

endmodule

// File: rtl/vga_scan_controller.sv
// ---------------------------------------------------------------------------
// vga_scan_controller
// VGA raster generator: scan counters, sync decode and a one-pixel output
// pipeline so colour and syncs reach the DAC together.
// Ports:
//   clk, rst_n        50 MHz clock, asynchronous active-low reset
//   scan_en           1 = scan runs, 0 = park at origin with blank outputs
//   color_in [2:0]    colour for the pixel currently at hPos/vPos
//   hPos, vPos [9:0]  current scan position
//   hsync, vsync      registered active-low syncs, aligned with color
//   color [2:0]       registered pixel colour (BLANK_COLOR outside active)
//   pix_tick          one-clk pulse per pixel period (clk/2)
//   line_start        pulse on the pixel tick at hPos=0
//   frame_start       pulse on the pixel tick at hPos=0, vPos=0
// ---------------------------------------------------------------------------
module vga_scan_controller
   import vga_pkg::*;
#(
   parameter int         H_VISIBLE   = vga_pkg::H_VISIBLE,
   parameter int         H_FRONT     = vga_pkg::H_FRONT,
   parameter int         H_SYNC      = vga_pkg::H_SYNC,
   parameter int         H_BACK      = vga_pkg::H_BACK,
   parameter int         V_VISIBLE   = vga_pkg::V_VISIBLE,
   parameter int         V_FRONT     = vga_pkg::V_FRONT,
   parameter int         V_SYNC      = vga_pkg::V_SYNC,
   parameter int         V_BACK      = vga_pkg::V_BACK,
   parameter logic [2:0] BLANK_COLOR = 3'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scan_en,
   input  logic [2:0] color_in,
   output logic [9:0] hPos,
   output logic [9:0] vPos,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] color,
   output logic       pix_tick,
   output logic       line_start,
   output logic       frame_start
);

   localparam int LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int FRAME_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_ACTIVE_END = coord_t'(H_VISIBLE);
   localparam coord_t V_ACTIVE_END = coord_t'(V_VISIBLE);
   localparam coord_t HSYNC_BEGIN  = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HSYNC_END    = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t VSYNC_BEGIN  = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VSYNC_END    = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

   logic activeArea;
   logic rawHsyncN;
   logic rawVsyncN;

   vga_sync_counter #(
      .H_TOTAL(LINE_TOTAL),
      .V_TOTAL(FRAME_TOTAL)
   ) syncCounter (
      .clk    (clk),
      .rst_n  (rst_n),
      .scanEn (scan_en),
      .pixTick(pix_tick),
      .hPos   (hPos),
      .vPos   (vPos)
   );

   // Decode the current position: visible window is strictly below the
   // visible extents, and the raw syncs are low only inside their pulse
   // windows. These describe the pixel being scanned now, one pixel ahead
   // of what the DAC sees.
   always_comb begin
      activeArea = 1'b0;
      rawHsyncN  = 1'b1;
      rawVsyncN  = 1'b1;
      activeArea = (hPos < H_ACTIVE_END) && (vPos < V_ACTIVE_END);
      rawHsyncN  = ~inSpan(hPos, HSYNC_BEGIN, HSYNC_END);
      rawVsyncN  = ~inSpan(vPos, VSYNC_BEGIN, VSYNC_END);
   end

   // Output pipeline: colour and both syncs are captured together on the
   // pixel tick, so they stay mutually aligned and lag the counters by one
   // pixel. color_in is only looked at on the tick; parking the scan forces
   // the idle (blank, syncs high) state on the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         color <= BLANK_COLOR;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else if (!scan_en) begin
         color <= BLANK_COLOR;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else if (pix_tick) begin
         color <= activeArea ? color_in : BLANK_COLOR;
         hsync <= rawHsyncN;
         vsync <= rawVsyncN;
      end
   end

   // Start markers are combinational so they sit in the very clk that the
   // tick for the origin pixel occupies.
   assign line_start  = pix_tick && (hPos == 10'd0);
   assign frame_start = line_start && (vPos == 10'd0);

endmodule

// File: tb/tb_vga_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_controller
// Directed bench for vga_scan_controller using a shrunken raster so whole
// frames fit in a short run: 16 visible + 4 front + 6 sync + 6 back = 32
// pixels per line (64 clks), 8 visible + 2 front + 2 sync + 3 back = 15
// lines per frame (960 clks). Blank colour is 3'd1 so it differs from zero.
// Raw hsync low for hPos 20..25, raw vsync low for vPos 10..11.
// ---------------------------------------------------------------------------
module tb_vga_scan_controller;

   localparam logic [2:0] BLANK = 3'd1;

   logic       clk;
   logic       rst_n;
   logic       scan_en;
   logic [2:0] color_in;
   logic [9:0] hPos;
   logic [9:0] vPos;
   logic       hsync;
   logic       vsync;
   logic [2:0] color;
   logic       pix_tick;
   logic       line_start;
   logic       frame_start;

   int totalChecks;
   int badChecks;
   int cycleCount;
   int originCycle;

   vga_scan_controller #(
      .H_VISIBLE  (16),
      .H_FRONT    (4),
      .H_SYNC     (6),
      .H_BACK     (6),
      .V_VISIBLE  (8),
      .V_FRONT    (2),
      .V_SYNC     (2),
      .V_BACK     (3),
      .BLANK_COLOR(BLANK)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_en    (scan_en),
      .color_in   (color_in),
      .hPos       (hPos),
      .vPos       (vPos),
      .hsync      (hsync),
      .vsync      (vsync),
      .color      (color),
      .pix_tick   (pix_tick),
      .line_start (line_start),
      .frame_start(frame_start)
   );

   // 100 MHz bench clock; the period is irrelevant to the design.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input int got, input int exp);
      totalChecks++;
      if (got !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic scan, input logic [2:0] colorIn);
      scan_en  = scan;
      color_in = colorIn;
   endtask

   // Advance one clk and sample 1 time unit after the rising edge.
   task automatic stepClk();
      @(posedge clk);
      #1;
      cycleCount++;
   endtask

   // Step until the scan shows (h, v) with the given tick level; an expired
   // budget is reported as a failed comparison.
   task automatic runUntil(input int h, input int v, input logic tick);
      int  n;
      bit  found;
      n     = 0;
      found = 0;
      do begin
         stepClk();
         n++;
         found = (hPos == 10'(h)) && (vPos == 10'(v)) && (pix_tick == tick);
      end while (!found && n < 2000);
      checkOutput($sformatf("reach_%0d_%0d", h, v), int'(found), 1);
   endtask

   initial begin
      totalChecks = 0;
      badChecks   = 0;
      cycleCount  = 0;
      rst_n       = 1'b0;
      applyStimulus(1'b1, 3'd5);

      // Reset state.
      stepClk();
      stepClk();
      checkOutput("rst_hPos", hPos, 0);
      checkOutput("rst_vPos", vPos, 0);
      checkOutput("rst_tick", pix_tick, 0);
      checkOutput("rst_hsync", hsync, 1);
      checkOutput("rst_vsync", vsync, 1);
      checkOutput("rst_color", color, BLANK);
      checkOutput("rst_line", line_start, 0);
      checkOutput("rst_frame", frame_start, 0);

      // First tick one clk after release, at the origin.
      rst_n = 1'b1;
      stepClk();
      originCycle = cycleCount;
      checkOutput("first_tick", pix_tick, 1);
      checkOutput("first_frame", frame_start, 1);
      checkOutput("first_line", line_start, 1);
      checkOutput("first_hPos", hPos, 0);
      stepClk();
      checkOutput("second_tick", pix_tick, 0);
      checkOutput("second_frame", frame_start, 0);
      checkOutput("second_hPos", hPos, 1);

      // Active pixel (4,0) presented while hPos=5.
      runUntil(5, 0, 1'b0);
      checkOutput("color_px4", color, 5);

      // color_in changes between ticks are ignored.
      color_in = 3'd6;
      stepClk();
      checkOutput("ign_tick", pix_tick, 1);
      color_in = 3'd3;
      stepClk();
      checkOutput("ign_color", color, 3);

      // Last visible pixel and first blank pixel of a line.
      runUntil(16, 0, 1'b0);
      checkOutput("color_px15", color, 3);
      runUntil(17, 0, 1'b0);
      checkOutput("color_px16", color, BLANK);

      // hsync window: pixels 20..25 low, presented at hPos 21..26.
      runUntil(20, 0, 1'b0);
      checkOutput("hsync_px19", hsync, 1);
      runUntil(21, 0, 1'b0);
      checkOutput("hsync_px20", hsync, 0);
      runUntil(26, 0, 1'b0);
      checkOutput("hsync_px25", hsync, 0);
      runUntil(27, 0, 1'b0);
      checkOutput("hsync_px26", hsync, 1);

      // Line period.
      runUntil(0, 1, 1'b1);
      checkOutput("line_pulse", line_start, 1);
      checkOutput("line_noframe", frame_start, 0);
      checkOutput("line_period", cycleCount - originCycle, 64);

      // Last visible line, then wrap into the blank lines.
      runUntil(1, 7, 1'b0);
      checkOutput("color_row7", color, 3);
      runUntil(1, 8, 1'b0);
      checkOutput("color_row8", color, BLANK);

      // vsync: lines 10..11 low, presented from (1,10) to (0,12).
      runUntil(0, 10, 1'b1);
      checkOutput("vsync_pre", vsync, 1);
      stepClk();
      checkOutput("vsync_low_first", vsync, 0);
      runUntil(0, 12, 1'b1);
      checkOutput("vsync_low_last", vsync, 0);
      stepClk();
      checkOutput("vsync_high", vsync, 1);

      // Frame period.
      runUntil(0, 0, 1'b1);
      checkOutput("frame_pulse", frame_start, 1);
      checkOutput("frame_period", cycleCount - originCycle, 960);

      // Park the scan while both syncs are low.
      runUntil(22, 10, 1'b0);
      checkOutput("park_pre_hsync", hsync, 0);
      checkOutput("park_pre_vsync", vsync, 0);
      scan_en = 1'b0;
      stepClk();
      checkOutput("park_hPos", hPos, 0);
      checkOutput("park_vPos", vPos, 0);
      checkOutput("park_tick", pix_tick, 0);
      checkOutput("park_hsync", hsync, 1);
      checkOutput("park_vsync", vsync, 1);
      checkOutput("park_color", color, BLANK);
      for (int i = 0; i < 9; i++) stepClk();
      checkOutput("park_hold_hPos", hPos, 0);
      checkOutput("park_hold_tick", pix_tick, 0);
      checkOutput("park_hold_frame", frame_start, 0);
      scan_en = 1'b1;
      stepClk();
      checkOutput("resume_tick", pix_tick, 1);
      checkOutput("resume_frame", frame_start, 1);

      // Asynchronous reset mid-line, away from any clock edge.
      runUntil(8, 0, 1'b0);
      checkOutput("arst_pre_color", color, 3);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_hPos", hPos, 0);
      checkOutput("arst_color", color, BLANK);
      checkOutput("arst_tick", pix_tick, 0);
      stepClk();
      stepClk();
      checkOutput("arst_hold_hPos", hPos, 0);
      rst_n = 1'b1;
      stepClk();
      checkOutput("arst_restart_tick", pix_tick, 1);
      checkOutput("arst_restart_frame", frame_start, 1);
      stepClk();
      checkOutput("arst_restart_hPos", hPos, 1);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
